// File: rtl/apb5_requester_arb.sv
// Round-robin arbiter sharing one APB5 requester port among NUM_REQ command ports.
// Sequences SETUP/ACCESS and routes each completion back to the issuing requester.
module apb5_requester_arb #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 4,
    parameter int USER_DATA_WIDTH = 8,
    parameter int USER_RESP_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     req_strb,
    input  logic [NUM_REQ*3-1:0]                  req_prot,
    input  logic [NUM_REQ-1:0]                    req_nse,
    input  logic [NUM_REQ*USER_REQ_WIDTH-1:0]     req_auser,
    input  logic [NUM_REQ*USER_DATA_WIDTH-1:0]    req_wuser,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [DATA_WIDTH-1:0]                 rsp_rdata,
    output logic                                  rsp_slverr,
    output logic [USER_DATA_WIDTH-1:0]            rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0]            rsp_buser,
    output logic                                  psel,
    output logic                                  penable,
    output logic                                  pwrite,
    output logic                                  pnse,
    output logic                                  pwakeup,
    output logic [ADDR_WIDTH-1:0]                 paddr,
    output logic [DATA_WIDTH-1:0]                 pwdata,
    output logic [DATA_WIDTH/8-1:0]               pstrb,
    output logic [2:0]                            pprot,
    output logic [USER_REQ_WIDTH-1:0]             pauser,
    output logic [USER_DATA_WIDTH-1:0]            pwuser,
    input  logic                                  pready,
    input  logic                                  pslverr,
    input  logic [DATA_WIDTH-1:0]                 prdata,
    input  logic [USER_DATA_WIDTH-1:0]            pruser,
    input  logic [USER_RESP_WIDTH-1:0]            pbuser
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state, state_next;
    logic [IDX_WIDTH-1:0] rr, owner, winner;
    logic                 found, grant_window, grant;
    int                   win_idx;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = rr;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[(int'(rr) + i) % NUM_REQ]) begin
                winner = IDX_WIDTH'((int'(rr) + i) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    assign win_idx      = int'(winner);
    assign grant_window = (state == IDLE) || ((state == ACCESS) && pready);
    assign grant        = !rst && grant_window && found;
    assign req_ready    = grant ? (ONE << winner) : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready) state_next = grant ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= '0;
            owner      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwakeup    <= 1'b0;
            pwrite     <= 1'b0;
            pnse       <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            pauser     <= '0;
            pwuser     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            rsp_ruser  <= '0;
            rsp_buser  <= '0;
        end else begin
            state   <= state_next;
            psel    <= (state_next != IDLE);
            penable <= (state_next == ACCESS);
            pwakeup <= (state != IDLE) || (|req_valid);

            // Completion uses the owner and direction of the transfer now ending,
            // before a same-cycle grant overwrites them.
            rsp_valid <= '0;
            if ((state == ACCESS) && pready) begin
                rsp_valid  <= ONE << owner;
                rsp_rdata  <= pwrite ? '0 : prdata;
                rsp_ruser  <= pwrite ? '0 : pruser;
                rsp_slverr <= pslverr;
                rsp_buser  <= pbuser;
            end

            if (grant) begin
                rr     <= (winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                owner  <= winner;
                pwrite <= req_write[win_idx];
                pnse   <= req_nse[win_idx];
                paddr  <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                pprot  <= req_prot[win_idx*3 +: 3];
                pauser <= req_auser[win_idx*USER_REQ_WIDTH +: USER_REQ_WIDTH];
                pwdata <= req_write[win_idx] ? req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
                pstrb  <= req_write[win_idx] ? req_strb[win_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
                pwuser <= req_write[win_idx] ? req_wuser[win_idx*USER_DATA_WIDTH +: USER_DATA_WIDTH] : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb5_requester_arb.sv
// Bench for apb5_requester_arb: vector table of single transfers, scoreboard for
// completions, and hand sequences for contention, reset mid-transfer and pwakeup.
module tb_apb5_requester_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0, req_ready, req_write = '0, req_nse = '0, rsp_valid;
    logic [47:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [15:0]  req_strb = '0;
    logic [11:0]  req_prot = '0;
    logic [15:0]  req_auser = '0;
    logic [31:0]  req_wuser = '0;
    logic [31:0]  rsp_rdata, pwdata, prdata = '0;
    logic         rsp_slverr, psel, penable, pwrite, pnse, pwakeup;
    logic [7:0]   rsp_ruser, pwuser, pruser = '0;
    logic [1:0]   rsp_buser, pbuser = '0;
    logic [11:0]  paddr;
    logic [3:0]   pstrb, pauser;
    logic [2:0]   pprot;
    logic         pready = 1'b0, pslverr = 1'b0;

    apb5_requester_arb dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .req_nse(req_nse), .req_auser(req_auser), .req_wuser(req_wuser),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_ruser(rsp_ruser), .rsp_buser(rsp_buser),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pnse(pnse), .pwakeup(pwakeup),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pauser(pauser), .pwuser(pwuser),
        .pready(pready), .pslverr(pslverr), .prdata(prdata), .pruser(pruser), .pbuser(pbuser)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse;
        logic [3:0]  auser;
        logic [7:0]  wuser;
        int          waits;
        logic [31:0] prdata;
        logic [7:0]  pruser;
        logic [1:0]  pbuser;
        logic        pslverr;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [7:0]  exp_pwuser;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_ruser;
        logic        exp_slverr;
        logic [1:0]  exp_buser;
    } vec_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] rdata;
        logic [7:0]  ruser;
        logic        slverr;
        logic [1:0]  buser;
    } rsp_t;

    vec_t vecs[5];
    rsp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int r);
        logic [3:0] one = 4'b0001;
        return one << r;
    endfunction

    task automatic drive_fields(input vec_t v);
        req_write[v.r]          = v.write;
        req_nse[v.r]            = v.nse;
        req_addr[v.r*12 +: 12]  = v.addr;
        req_wdata[v.r*32 +: 32] = v.wdata;
        req_strb[v.r*4 +: 4]    = v.strb;
        req_prot[v.r*3 +: 3]    = v.prot;
        req_auser[v.r*4 +: 4]   = v.auser;
        req_wuser[v.r*8 +: 8]   = v.wuser;
    endtask

    // Completions are popped in order and compared against what the bench expected.
    always @(negedge clk) begin
        if (!rst && rsp_valid != 4'b0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_rsp", rsp_valid, 4'b0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("sb_rsp_valid", rsp_valid, e.valid);
                check("sb_rsp_rdata", rsp_rdata, e.rdata);
                check("sb_rsp_ruser", rsp_ruser, e.ruser);
                check("sb_rsp_slverr", rsp_slverr, e.slverr);
                check("sb_rsp_buser", rsp_buser, e.buser);
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int   n;
        rsp_t e;
        check("idle_pwakeup", pwakeup, 1'b0);
        check("idle_psel", psel, 1'b0);
        drive_fields(v);
        req_valid = oh(v.r);
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 8) begin
            tick();
            #1;
            n++;
        end
        check("grant", req_ready, oh(v.r));
        tick();
        check("setup_ready", req_ready, 4'b0);
        req_valid = '0;
        check("setup_psel", psel, 1'b1);
        check("setup_penable", penable, 1'b0);
        check("setup_paddr", paddr, v.addr);
        check("setup_pwrite", pwrite, v.write);
        check("setup_pwdata", pwdata, v.exp_pwdata);
        check("setup_pstrb", pstrb, v.exp_pstrb);
        check("setup_pprot", pprot, v.prot);
        check("setup_pnse", pnse, v.nse);
        check("setup_pauser", pauser, v.auser);
        check("setup_pwuser", pwuser, v.exp_pwuser);
        check("setup_pwakeup", pwakeup, 1'b1);
        tick();
        for (int w = 0; w < v.waits; w++) begin
            check("wait_penable", penable, 1'b1);
            check("wait_psel", psel, 1'b1);
            check("wait_paddr", paddr, v.addr);
            check("wait_rsp_valid", rsp_valid, 4'b0);
            tick();
        end
        check("access_penable", penable, 1'b1);
        check("access_pwakeup", pwakeup, 1'b1);
        pready  = 1'b1;
        prdata  = v.prdata;
        pruser  = v.pruser;
        pbuser  = v.pbuser;
        pslverr = v.pslverr;
        e = '{oh(v.r), v.exp_rdata, v.exp_ruser, v.exp_slverr, v.exp_buser};
        sb_q.push_back(e);
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        check("done_rsp_valid", rsp_valid, oh(v.r));
        check("done_rsp_slverr", rsp_slverr, v.exp_slverr);
        check("done_psel", psel, 1'b0);
        check("done_penable", penable, 1'b0);
        check("done_paddr_hold", paddr, v.addr);
        check("done_pwakeup", pwakeup, 1'b1);
        tick();
        check("after_rsp_valid", rsp_valid, 4'b0);
        check("after_pwakeup", pwakeup, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        r  wr    addr    wdata         strb  prot    nse   au    wu     wt prdata        pruser pb   err   pwdata        pstrb pwuser rdata         ruser slverr buser
        vecs[0] = '{0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b010, 1'b1, 4'h5, 8'h3C, 0, 32'hFFFFFFFF, 8'h11, 2'd1, 1'b0, 32'hDEADBEEF, 4'hF, 8'h3C, 32'h0,        8'h00, 1'b0, 2'd1};
        vecs[1] = '{2, 1'b0, 12'h7FC, 32'hCAFEF00D, 4'h6, 3'b001, 1'b0, 4'hA, 8'h77, 3, 32'h12345678, 8'hA5, 2'd2, 1'b0, 32'h0,        4'h0, 8'h00, 32'h12345678, 8'hA5, 1'b0, 2'd2};
        vecs[2] = '{1, 1'b1, 12'h444, 32'h01020304, 4'h3, 3'b111, 1'b0, 4'h1, 8'h5A, 1, 32'h0BADBEEF, 8'h42, 2'd3, 1'b1, 32'h01020304, 4'h3, 8'h5A, 32'h0,        8'h00, 1'b1, 2'd3};
        vecs[3] = '{1, 1'b0, 12'h008, 32'h55555555, 4'hF, 3'b000, 1'b1, 4'hF, 8'hFF, 0, 32'h89ABCDEF, 8'h3C, 2'd0, 1'b0, 32'h0,        4'h0, 8'h00, 32'h89ABCDEF, 8'h3C, 1'b0, 2'd0};
        vecs[4] = '{3, 1'b1, 12'hFFF, 32'hA5A5A5A5, 4'h8, 3'b100, 1'b1, 4'h7, 8'h81, 2, 32'h0,        8'h00, 2'd1, 1'b0, 32'hA5A5A5A5, 4'h8, 8'h81, 32'h0,        8'h00, 1'b0, 2'd1};

        // Contention: all requesters valid from reset, zero wait states.
        for (int i = 0; i < 4; i++) begin
            req_write[i]          = 1'b1;
            req_addr[i*12 +: 12]  = 12'h100 + 12'(i);
            req_wdata[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
            req_strb[i*4 +: 4]    = 4'hF;
        end
        req_valid = 4'b1111;
        tick();
        tick();
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwakeup", pwakeup, 1'b0);
        check("rst_paddr", paddr, 12'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pstrb", pstrb, 4'h0);
        check("rst_pprot", pprot, 3'h0);
        check("rst_pnse", pnse, 1'b0);
        check("rst_pauser", pauser, 4'h0);
        check("rst_pwuser", pwuser, 8'h0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_req_ready", req_ready, 4'b0);
        check("rst_rsp_valid", rsp_valid, 4'b0);
        check("rst_rsp_data", {rsp_rdata, rsp_ruser, rsp_buser, rsp_slverr}, 43'h0);
        prdata = 32'hFEEDFACE;
        pruser = 8'h99;
        pbuser = 2'd2;
        pready = 1'b1;
        rst    = 1'b0;
        for (int g = 0; g < 5; g++) begin
            rsp_t e;
            #1;
            check("rr_grant", req_ready, oh(g % 4));
            e = '{oh(g % 4), 32'h0, 8'h00, 1'b0, 2'd2};
            sb_q.push_back(e);
            tick();
            check("b2b_setup_psel", psel, 1'b1);
            check("b2b_setup_penable", penable, 1'b0);
            check("b2b_setup_paddr", paddr, 12'h100 + 12'(g % 4));
            tick();
            check("b2b_access_psel", psel, 1'b1);
            check("b2b_access_penable", penable, 1'b1);
            if (g == 4) req_valid = '0;
        end
        #1;
        check("b2b_end_ready", req_ready, 4'b0);
        tick();
        pready = 1'b0;
        check("b2b_end_psel", psel, 1'b0);
        tick();

        // Single transfers from the vector table.
        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset while a transfer is stalled in ACCESS.
        drive_fields(vecs[3]);
        req_valid = oh(1);
        tick();
        req_valid = '0;
        check("mr_setup_psel", psel, 1'b1);
        tick();
        tick();
        tick();
        check("mr_access_penable", penable, 1'b1);
        rst = 1'b1;
        tick();
        check("mr_psel", psel, 1'b0);
        check("mr_penable", penable, 1'b0);
        check("mr_rsp_valid", rsp_valid, 4'b0);
        check("mr_pwakeup", pwakeup, 1'b0);
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("mr_rr_reset", req_ready, 4'b0010);
        req_valid = '0;
        tick();
        check("mr_no_rsp", rsp_valid, 4'b0);
        run_txn(vecs[4]);

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
